// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit shift register with a built-in LSB-first serial-transmit sequencer.
// Modes: hold, load, logical shift, rotate and clear. A start request shifts q out on sout over WIDTH cycles.
module shift_reg_universal #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin,
    input  logic                         start,
    output logic [WIDTH-1:0]             q,
    output logic                         sout,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CW-1:0]     count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= RESET_VAL;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and registered-output logic; busy/done are decoded one cycle early.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        count_d = count_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start) begin
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    case (mode)
                        MODE_LOAD: q_d = d;
                        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin};
                        MODE_SHR:  q_d = {sin, q_q[WIDTH-1:1]};
                        MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                        MODE_CLR:  q_d = '0;
                        default:   q_d = q_q;
                    endcase
                end
            end

            S_SHIFT: begin
                q_d     = {sin, q_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign q     = q_q;
    assign sout  = q_q[0];
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule
